iter_muldiv_unit: RTL

//   Multi-cycle integer multiply/divide unit that executes the RV M-extension ops
//   (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) beside the single-cycle ALU in EXU.

---
 rtl/muldiv_if.sv | 28 ++
 rtl/iter_muldiv_unit.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/muldiv_if.sv
// muldiv_if: request/response handshake bundle for iter_muldiv_unit.
// master = EXU side issuing ops, slave = the mul/div unit.
interface muldiv_if #(
  parameter int XLEN = 64,
  parameter int OPW  = 3
);
  logic            in_valid;
  logic            in_ready;
  logic [OPW-1:0]  in_op;
  logic            in_word;
  logic [XLEN-1:0] in_a;
  logic [XLEN-1:0] in_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_result;

  modport master (
    output in_valid, in_op, in_word, in_a, in_b,
    output out_ready,
    input  in_ready, out_valid, out_result
  );

  modport slave (
    input  in_valid, in_op, in_word, in_a, in_b,
    input  out_ready,
    output in_ready, out_valid, out_result
  );
endinterface

// File: rtl/iter_muldiv_unit.sv
// iter_muldiv_unit: iterative RV M-ext mul/div on one shift datapath.
// MULDIV_WORD_OP_EN enables RV64 *W ops (XLEN=64 only).
module iter_muldiv_unit #(
  parameter int XLEN = 64,
  parameter int OPW  = 3
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    flush,
  output logic    busy,
  muldiv_if.slave bus
);
  localparam int CW = $clog2(XLEN);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
`ifdef MULDIV_WORD_OP_EN
  localparam bit WORD_EN = (XLEN == 64);
`else
  localparam bit WORD_EN = 1'b0;
`endif

  function automatic logic [XLEN-1:0] wfit(
    input logic [XLEN-1:0] v,
    input logic            w
  );
    return w ? XLEN'(signed'(v[31:0])) : v;
  endfunction

  logic [1:0]        r_state;
  logic [CW-1:0]     r_cnt;
  logic [2:0]        r_op;
  logic              r_word;
  logic              r_neg;
  logic              r_rneg;
  logic [2*XLEN-1:0] r_acc;
  logic [XLEN-1:0]   r_b;
  logic [XLEN-1:0]   r_d;
  logic [XLEN-1:0]   r_res;

  logic [2:0]        w_op;
  logic              w_word;
  logic              w_asgn;
  logic              w_bsgn;
  logic              w_aneg;
  logic              w_bneg;
  logic              w_dz;
  logic              w_ovf;
  logic [XLEN-1:0]   w_a;
  logic [XLEN-1:0]   w_b;
  logic [XLEN-1:0]   w_amag;
  logic [XLEN-1:0]   w_bmag;
  logic [XLEN-1:0]   w_min;
  logic [XLEN-1:0]   w_fast;
  logic [XLEN:0]     w_rsh;
  logic              w_ge;
  logic [XLEN:0]     w_rnew;
  logic [2*XLEN-1:0] w_next;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_q;
  logic [XLEN-1:0]   w_r;
  logic [XLEN-1:0]   w_sel;
  logic [XLEN-1:0]   w_fin;

  assign w_op   = bus.in_op[2:0];
  assign w_word = WORD_EN & bus.in_word;
  assign w_asgn = (w_op[2] & ~w_op[0])
                | (~w_op[2] & (w_op[0] ^ w_op[1]));
  assign w_bsgn = (w_op == 3'd1) | (w_op[2] & ~w_op[0]);

  always_comb begin
    w_a    = wfit(bus.in_a, w_word);
    w_b    = wfit(bus.in_b, w_word);
    w_aneg = w_asgn & w_a[XLEN-1];
    w_bneg = w_bsgn & w_b[XLEN-1];
    w_amag = w_aneg ? -w_a : w_a;
    w_bmag = w_bneg ? -w_b : w_b;
    w_min  = wfit({1'b1, {(XLEN-1){1'b0}}}, 1'b0);
    if (w_word)
      w_min = XLEN'(signed'(32'h8000_0000));
    w_dz   = w_op[2] & (w_b == '0);
    w_ovf  = w_op[2] & ~w_op[0]
           & (w_a == w_min) & (w_b == '1);
    if (w_op[1])
      w_fast = w_dz ? w_a : '0;
    else
      w_fast = w_dz ? '1 : w_a;
  end

  // div: {rem, dividend} shifts left, quotient bits enter at LSB
  always_comb begin
    w_rsh  = r_acc[2*XLEN-1:XLEN-1];
    w_ge   = w_rsh >= {1'b0, r_d};
    w_rnew = w_ge ? w_rsh - {1'b0, r_d} : w_rsh;
    if (r_op[2])
      w_next = {w_rnew[XLEN-1:0],
                r_acc[XLEN-2:0], w_ge};
    else
      w_next = {r_acc[2*XLEN-2:0], 1'b0}
             + (r_b[XLEN-1]
                ? {{XLEN{1'b0}}, r_d} : '0);
    w_prod = r_neg ? -w_next : w_next;
    w_q    = r_neg ? -w_next[XLEN-1:0]
                   : w_next[XLEN-1:0];
    w_r    = r_rneg ? -w_next[2*XLEN-1:XLEN]
                    : w_next[2*XLEN-1:XLEN];
    unique case (1'b1)
      r_op[2] && r_op[1]:
        w_sel = w_r;
      r_op[2] && !r_op[1]:
        w_sel = w_q;
      !r_op[2] && r_op[1:0] == 2'b00:
        w_sel = w_prod[XLEN-1:0];
      default:
        w_sel = r_word ? '0
              : w_prod[2*XLEN-1:XLEN];
    endcase
    w_fin = wfit(w_sel, r_word);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_op    <= '0;
      r_word  <= 1'b0;
      r_neg   <= 1'b0;
      r_rneg  <= 1'b0;
      r_acc   <= '0;
      r_b     <= '0;
      r_d     <= '0;
      r_res   <= '0;
    end else if (flush) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: if (bus.in_valid) begin
          r_op   <= w_op;
          r_word <= w_word;
          r_neg  <= w_aneg ^ w_bneg;
          r_rneg <= w_aneg;
          r_cnt  <= w_word ? CW'(31) : CW'(XLEN-1);
          if (w_dz || w_ovf) begin
            r_res   <= w_fast;
            r_state <= S_DONE;
          end else begin
            r_state <= S_BUSY;
            // W ops pre-shift so MSB-first iteration sees bit 31 first
            if (w_op[2]) begin
              r_acc <= {{XLEN{1'b0}},
                        w_word ? w_amag << 32 : w_amag};
              r_d   <= w_bmag;
            end else begin
              r_acc <= '0;
              r_b   <= w_word ? w_bmag << 32 : w_bmag;
              r_d   <= w_amag;
            end
          end
        end
        S_BUSY: begin
          r_acc <= w_next;
          r_b   <= r_b << 1;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == '0) begin
            r_res   <= w_fin;
            r_state <= S_DONE;
          end
        end
        S_DONE: if (bus.out_ready)
          r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready   = (r_state == S_IDLE);
  assign bus.out_valid  = (r_state == S_DONE);
  assign bus.out_result = r_res;
  assign busy           = (r_state != S_IDLE);
endmodule
